// File: rtl/adder_operand_loader_if.sv
// Chunk-stream input and operand-pair output bundle for adder_operand_loader.
interface adder_operand_loader_if #(
  parameter int WIDTH   = 28,
  parameter int CHUNK_W = 7
);
  logic               in_valid;
  logic [CHUNK_W-1:0] in_data;
  logic               in_cin;
  logic               in_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               c_in;

  modport slave (
    input  in_valid, in_data, in_cin, flush, out_ready,
    output in_ready, out_valid, a, b, c_in
  );

  modport master (
    output in_valid, in_data, in_cin, flush, out_ready,
    input  in_ready, out_valid, a, b, c_in
  );
endinterface

// File: rtl/adder_operand_loader.sv
// Deserialises a chunk stream into one (a, b, c_in) operand pair and holds it
// on a valid/ready handshake until the adder-side consumer accepts it.
module adder_operand_loader #(
  parameter int WIDTH   = 28,
  parameter int CHUNK_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  adder_operand_loader_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic xfer;
  logic last_chunk;

  // in_ready_q is only high in the load states, so a transfer implies LOAD_A/LOAD_B
  assign xfer       = bus.in_valid && in_ready_q && !bus.flush;
  assign last_chunk = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD_A: begin
        if (bus.flush) begin
          cnt_d = '0;
        end else if (xfer) begin
          if (last_chunk) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = LOAD_A;
        end else if (xfer) begin
          if (last_chunk) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          cnt_d   = '0;
          state_d = LOAD_A;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LOAD_A;
      end
    endcase
  end

  // Handshake flags are registered copies of the next state, so neither
  // in_ready nor out_valid has a combinational path from out_ready.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    out_valid_d = (state_d == HOLD);
    in_ready_d  = (state_d != HOLD);
    if (xfer && state_q == LOAD_A) begin
      a_d[int'(cnt_q)*CHUNK_W +: CHUNK_W] = bus.in_data;
      if (cnt_q == '0) begin
        cin_d = bus.in_cin;
      end
    end
    if (xfer && state_q == LOAD_B) begin
      b_d[int'(cnt_q)*CHUNK_W +: CHUNK_W] = bus.in_data;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c_in      = cin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_adder_operand_loader.sv
// Self-checking bench for adder_operand_loader: directed scenarios followed by
// randomized traffic, all compared against a chunk-accumulating reference model.
module tb_adder_operand_loader;
  localparam int W  = 28;
  localparam int CW = 7;
  localparam int N  = W / CW;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  adder_operand_loader_if #(.WIDTH(W), .CHUNK_W(CW)) bus ();

  adder_operand_loader #(.WIDTH(W), .CHUNK_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: counts chunks of the pair in progress and splices each
  // chunk into the operand it belongs to by shift/mask arithmetic.
  logic [W-1:0] a_m, b_m;
  logic         cin_m;
  bit           held;
  int           n_rx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] splice(input logic [W-1:0] word, input int k,
                                          input logic [CW-1:0] d);
    logic [W-1:0] mask;
    mask = {{(W-CW){1'b0}}, {CW{1'b1}}} << (k * CW);
    return (word & ~mask) | ((W'(d)) << (k * CW));
  endfunction

  function automatic logic [CW-1:0] chunk_of(input logic [W-1:0] x, input int k);
    logic [W-1:0] t;
    t = x >> (k * CW);
    return t[CW-1:0];
  endfunction

  task automatic model_step();
    if (rst) begin
      a_m = '0; b_m = '0; cin_m = 1'b0; held = 0; n_rx = 0;
    end else if (held) begin
      if (bus.out_ready) begin
        held = 0; n_rx = 0;
      end
    end else if (bus.flush) begin
      n_rx = 0;
    end else if (bus.in_valid) begin
      if (n_rx < N) begin
        a_m = splice(a_m, n_rx, bus.in_data);
        if (n_rx == 0) cin_m = bus.in_cin;
      end else begin
        b_m = splice(b_m, n_rx - N, bus.in_data);
      end
      n_rx++;
      if (n_rx == 2 * N) begin
        held = 1; n_rx = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("in_ready",  64'(bus.in_ready),  64'(!held));
    chk("out_valid", 64'(bus.out_valid), 64'(held));
    chk("a",         64'(bus.a),         64'(a_m));
    chk("b",         64'(bus.b),         64'(b_m));
    chk("c_in",      64'(bus.c_in),      64'(cin_m));
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_cin = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic expect_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    chk({tag, "_a"},         64'(bus.a),         64'd0);
    chk({tag, "_b"},         64'(bus.b),         64'd0);
    chk({tag, "_c_in"},      64'(bus.c_in),      64'd0);
  endtask

  // Streams chunks [first, last) of the pair; the final call always ends on a transfer.
  task automatic send_chunks(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cin, input int first, input int last,
                             input bit toggle);
    for (int i = first; i < last; i++) begin
      if (toggle) begin
        bus.in_valid = 1'b0;
        bus.in_data  = ~bus.in_data;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = (i < N) ? chunk_of(av, i) : chunk_of(bv, i - N);
      bus.in_cin   = (i == 0) ? cin : ~cin;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int budget = 40;
    while (!bus.out_valid && budget > 0) begin
      tick();
      budget--;
    end
    chk({tag, "_valid_timeout"}, 64'(bus.out_valid), 64'd1);
  endtask

  logic [W:0] sum;

  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    a_m = '0; b_m = '0; cin_m = 1'b0; held = 0; n_rx = 0;
    tick();
    tick();
    expect_reset_values("reset");
    rst = 1'b0;

    // 1: basic pair, consumer always ready; out_valid rises right after last b chunk
    bus.out_ready = 1'b1;
    send_chunks(28'h080C101, 28'hFFFFFFF, 1'b1, 0, 2 * N - 1, 0);
    chk("t1_no_early_valid", 64'(bus.out_valid), 64'd0);
    send_chunks(28'h080C101, 28'hFFFFFFF, 1'b1, 2 * N - 1, 2 * N, 0);
    chk("t1_valid",  64'(bus.out_valid), 64'd1);
    chk("t1_a",      64'(bus.a),         64'h080C101);
    chk("t1_b",      64'(bus.b),         64'hFFFFFFF);
    chk("t1_cin",    64'(bus.c_in),      64'd1);
    tick();
    chk("t1_pulse",  64'(bus.out_valid), 64'd0);
    chk("t1_ready",  64'(bus.in_ready),  64'd1);

    // 2: consumer stalls 5 cycles, then accepts; the next chunk lands in a[6:0]
    bus.out_ready = 1'b0;
    send_chunks(28'h080C101, 28'hFFFFFFF, 1'b1, 0, 2 * N, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_ready", 64'(bus.in_ready), 64'd0);
      chk("t2_stall_a",     64'(bus.a),        64'h080C101);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t2_accepted", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b1; bus.in_data = 7'h2A; bus.in_cin = 1'b0;
    tick();
    chk("t2_next_chunk", 64'(bus.a[CW-1:0]), 64'h2A);
    chk("t2_next_cin",   64'(bus.c_in),      64'd0);
    idle_inputs();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // 3: in_valid toggling every cycle
    bus.out_ready = 1'b0;
    send_chunks(28'h0000001, 28'h0000002, 1'b0, 0, 2 * N, 1);
    chk("t3_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_a",     64'(bus.a),         64'h0000001);
    chk("t3_b",     64'(bus.b),         64'h0000002);
    bus.out_ready = 1'b1;
    tick();

    // 4: flush after two a chunks drops the concurrent chunk
    bus.out_ready = 1'b0;
    send_chunks(28'h5555555, 28'h0, 1'b1, 0, 2, 0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 7'h33;
    tick();
    idle_inputs();
    send_chunks(28'h1234567, 28'h7654321, 1'b0, 0, 2 * N, 0);
    chk("t4_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_a",     64'(bus.a),         64'h1234567);
    chk("t4_b",     64'(bus.b),         64'h7654321);
    chk("t4_cin",   64'(bus.c_in),      64'd0);
    bus.out_ready = 1'b1;
    tick();

    // 5: reset during LOAD_B chunk 2, then flush and reset during HOLD
    bus.out_ready = 1'b0;
    send_chunks(28'h0ABCDEF, 28'h0FEDCBA, 1'b1, 0, N + 2, 0);
    bus.in_valid = 1'b1; bus.in_data = 7'h11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    expect_reset_values("t5_rst_loadb");
    send_chunks(28'h0ABCDEF, 28'h0FEDCBA, 1'b1, 0, 2 * N, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t5_flush_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("t5_flush_hold_a",     64'(bus.a),         64'h0ABCDEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_reset_values("t5_rst_hold");

    // 6: operands feeding the adder produce the carried-out sum
    bus.out_ready = 1'b1;
    send_chunks(28'hFFFFFFF, 28'h0000001, 1'b0, 0, 2 * N, 0);
    wait_valid("t6");
    sum = {1'b0, bus.a} + {1'b0, bus.b} + (W + 1)'(bus.c_in);
    chk("t6_sum", 64'(sum), 64'h10000000);
    tick();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = CW'($urandom);
      bus.in_cin    = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
